// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the load/store control sequencer:
// state encoding, opcodes, ALU select codes, MDR mux codes and the
// control-signal word produced by the decoder.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 5;
    localparam int ALU_W    = 4;

    localparam logic [OPCODE_W-1:0] OP_LD  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_LDI = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_ST  = 5'd2;

    localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd2;

    localparam logic [1:0] MDR_SEL_BUS = 2'b00;
    localparam logic [1:0] MDR_SEL_MEM = 2'b01;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_IDLE  = 4'd1,
        ST_T0    = 4'd2,
        ST_T1    = 4'd3,
        ST_T2    = 4'd4,
        ST_T3    = 4'd5,
        ST_T4    = 4'd6,
        ST_T5    = 4'd7,
        ST_T6    = 4'd8,
        ST_T7    = 4'd9,
        ST_HALT  = 4'd10
    } state_e;

    typedef struct packed {
        logic             pc_out;
        logic             zlow_out;
        logic             mdr_out;
        logic             ba_out;
        logic             c_out;
        logic             r_out;
        logic             mar_in;
        logic             pc_in;
        logic             mdr_in;
        logic             ir_in;
        logic             y_in;
        logic             zlow_in;
        logic             r_in;
        logic             inc_pc;
        logic             read;
        logic             write;
        logic             gra;
        logic             grb;
        logic             grc;
        logic [1:0]       mdr_read;
        logic [ALU_W-1:0] control;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    // Steps that talk to memory and may therefore stall on mem_ready.
    function automatic logic is_mem_step(input state_e st, input logic [OPCODE_W-1:0] op);
        return (st == ST_T1) ||
               ((st == ST_T6) && (op == OP_LD)) ||
               ((st == ST_T7) && (op == OP_ST));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, latched opcode) into the datapath
// control word. Anything not explicitly raised for a step stays 0.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o
);

    // Moore decode: one control word per step, opcode selects the tail.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_T0: begin
                ctrl_o.pc_out  = 1'b1;
                ctrl_o.mar_in  = 1'b1;
                ctrl_o.inc_pc  = 1'b1;
                ctrl_o.zlow_in = 1'b1;
            end
            ST_T1: begin
                ctrl_o.zlow_out = 1'b1;
                ctrl_o.pc_in    = 1'b1;
                ctrl_o.read     = 1'b1;
                ctrl_o.mdr_read = MDR_SEL_MEM;
                ctrl_o.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
            end
            ST_T3: begin
                ctrl_o.grb    = 1'b1;
                ctrl_o.ba_out = 1'b1;
                ctrl_o.y_in   = 1'b1;
            end
            ST_T4: begin
                ctrl_o.c_out   = 1'b1;
                ctrl_o.control = ALU_ADD;
                ctrl_o.zlow_in = 1'b1;
            end
            ST_T5: begin
                ctrl_o.zlow_out = 1'b1;
                if (opcode_i == OP_LDI) begin
                    ctrl_o.gra  = 1'b1;
                    ctrl_o.r_in = 1'b1;
                end else begin
                    ctrl_o.mar_in = 1'b1;
                end
            end
            ST_T6: begin
                if (opcode_i == OP_LD) begin
                    ctrl_o.read     = 1'b1;
                    ctrl_o.mdr_read = MDR_SEL_MEM;
                    ctrl_o.mdr_in   = 1'b1;
                end else if (opcode_i == OP_ST) begin
                    ctrl_o.gra      = 1'b1;
                    ctrl_o.r_out    = 1'b1;
                    ctrl_o.mdr_read = MDR_SEL_BUS;
                    ctrl_o.mdr_in   = 1'b1;
                end
            end
            ST_T7: begin
                if (opcode_i == OP_LD) begin
                    ctrl_o.mdr_out = 1'b1;
                    ctrl_o.gra     = 1'b1;
                    ctrl_o.r_in    = 1'b1;
                end else if (opcode_i == OP_ST) begin
                    ctrl_o.write = 1'b1;
                end
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/ldst_control_unit.sv
// Hardwired sequencer for ld / ldi / st: fetch, decode, address add and
// the per-opcode tail, with memory-ready stalls, stop parking and an
// illegal-opcode trap.
//
//   state | meaning
//   RESET | after reset, all outputs low
//   IDLE  | parked by stop, all outputs low
//   T0    | PC to MAR, start PC increment
//   T1    | incremented PC back, memory read into MDR (may stall)
//   T2    | MDR to IR, opcode latched and decoded
//   T3    | base register to Y
//   T4    | Y + constant into Z
//   T5    | ldi: Z to Ra (last) / ld,st: Z to MAR
//   T6    | ld: memory read (may stall) / st: Ra to MDR
//   T7    | ld: MDR to Ra / st: memory write (may stall)
//   HALT  | illegal opcode trapped, leave only by reset
module ldst_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IRval,
    input  logic             mem_ready,
    input  logic             stop,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             BAout,
    output logic             Cout,
    output logic             Rout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             Rin,
    output logic             IncPc,
    output logic             read,
    output logic             write,
    output logic             GRA,
    output logic             GRB,
    output logic             GRC,
    output logic [1:0]       mdr_read,
    output logic [ALU_W-1:0] control,
    output logic             halted,
    output logic [3:0]       step
);

    state_e              state_q, state_d;
    state_e              next_instr;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [OPCODE_W-1:0] ir_opcode;
    logic                mem_hold;
    logic                unused_ir_fields;
    ctrl_t               ctrl;

    assign ir_opcode        = IRval[31:27];
    assign unused_ir_fields = ^IRval[26:0];
    assign next_instr       = stop ? ST_IDLE : ST_T0;
    assign mem_hold         = (MEM_WAIT == 1'b1) && is_mem_step(state_q, opcode_q) && !mem_ready;

    // State and opcode latch; reset abandons any partial instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RESET;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Step sequencing, memory stalls, decode trap and stop at boundaries.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_RESET, ST_IDLE: state_d = next_instr;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (!mem_hold) state_d = ST_T2;
            ST_T2: begin
                // IR loads from the bus this edge, so decode what IRval presents now.
                opcode_d = ir_opcode;
                state_d  = is_legal_op(ir_opcode) ? ST_T3 : ST_HALT;
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (opcode_q == OP_LDI) ? next_instr : ST_T6;
            ST_T6:   if (!mem_hold) state_d = ST_T7;
            ST_T7:   if (!mem_hold) state_d = next_instr;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RESET;
        endcase
    end

    ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode_q),
        .ctrl_o   (ctrl)
    );

    // Drive the datapath ports from the decoded control word.
    always_comb begin
        PCout    = ctrl.pc_out;
        Zlowout  = ctrl.zlow_out;
        MDRout   = ctrl.mdr_out;
        BAout    = ctrl.ba_out;
        Cout     = ctrl.c_out;
        Rout     = ctrl.r_out;
        MARin    = ctrl.mar_in;
        PCin     = ctrl.pc_in;
        MDRin    = ctrl.mdr_in;
        IRin     = ctrl.ir_in;
        Yin      = ctrl.y_in;
        Zlowin   = ctrl.zlow_in;
        Rin      = ctrl.r_in;
        IncPc    = ctrl.inc_pc;
        read     = ctrl.read;
        write    = ctrl.write;
        GRA      = ctrl.gra;
        GRB      = ctrl.grb;
        GRC      = ctrl.grc;
        mdr_read = ctrl.mdr_read;
        control  = ctrl.control;
        halted   = (state_q == ST_HALT);
        step     = state_q;
    end

endmodule

// File: tb/tb_ldst_control_unit.sv
// Directed bench for ldst_control_unit: ldi/ld/st sequences, memory
// stalls, stop parking, illegal-opcode trap and asynchronous reset.
`timescale 1ns/1ps
module tb_ldst_control_unit;
    import cpu_ctrl_pkg::*;

    localparam logic [31:0] IR_LDI = 32'h0880_0055;
    localparam logic [31:0] IR_LD  = 32'h0108_0010;
    localparam logic [31:0] IR_ST  = 32'h1018_0020;
    localparam logic [31:0] IR_BAD = 32'hF800_0000;

    // Output vector bit positions (msb PCout ... lsb control[0]).
    localparam logic [24:0] M_PCOUT   = 25'd1 << 24;
    localparam logic [24:0] M_ZLOWOUT = 25'd1 << 23;
    localparam logic [24:0] M_MDROUT  = 25'd1 << 22;
    localparam logic [24:0] M_BAOUT   = 25'd1 << 21;
    localparam logic [24:0] M_COUT    = 25'd1 << 20;
    localparam logic [24:0] M_ROUT    = 25'd1 << 19;
    localparam logic [24:0] M_MARIN   = 25'd1 << 18;
    localparam logic [24:0] M_PCIN    = 25'd1 << 17;
    localparam logic [24:0] M_MDRIN   = 25'd1 << 16;
    localparam logic [24:0] M_IRIN    = 25'd1 << 15;
    localparam logic [24:0] M_YIN     = 25'd1 << 14;
    localparam logic [24:0] M_ZLOWIN  = 25'd1 << 13;
    localparam logic [24:0] M_RIN     = 25'd1 << 12;
    localparam logic [24:0] M_INCPC   = 25'd1 << 11;
    localparam logic [24:0] M_READ    = 25'd1 << 10;
    localparam logic [24:0] M_WRITE   = 25'd1 << 9;
    localparam logic [24:0] M_GRA     = 25'd1 << 8;
    localparam logic [24:0] M_GRB     = 25'd1 << 7;
    localparam logic [24:0] M_MDRMEM  = 25'h10;
    localparam logic [24:0] M_ADD     = 25'h2;

    localparam logic [24:0] E_ZERO   = 25'd0;
    localparam logic [24:0] E_T0     = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
    localparam logic [24:0] E_T1     = M_ZLOWOUT | M_PCIN | M_READ | M_MDRMEM | M_MDRIN;
    localparam logic [24:0] E_T2     = M_MDROUT | M_IRIN;
    localparam logic [24:0] E_T3     = M_GRB | M_BAOUT | M_YIN;
    localparam logic [24:0] E_T4     = M_COUT | M_ADD | M_ZLOWIN;
    localparam logic [24:0] E_T5_LDI = M_ZLOWOUT | M_GRA | M_RIN;
    localparam logic [24:0] E_T5_MEM = M_ZLOWOUT | M_MARIN;
    localparam logic [24:0] E_T6_LD  = M_READ | M_MDRMEM | M_MDRIN;
    localparam logic [24:0] E_T7_LD  = M_MDROUT | M_GRA | M_RIN;
    localparam logic [24:0] E_T6_ST  = M_GRA | M_ROUT | M_MDRIN;
    localparam logic [24:0] E_T7_ST  = M_WRITE;

    logic        clk;
    logic        reset;
    logic [31:0] IRval;
    logic        mem_ready;
    logic        mem_ready_nw;
    logic        stop;
    wire  [24:0] outs;
    wire         halted;
    wire  [3:0]  step;
    wire  [24:0] nw_outs;
    wire         nw_halted;
    wire  [3:0]  nw_step;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0       = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ldst_control_unit #(.MEM_WAIT(1'b1)) dut (
        .clk(clk), .reset(reset), .IRval(IRval), .mem_ready(mem_ready), .stop(stop),
        .PCout(outs[24]), .Zlowout(outs[23]), .MDRout(outs[22]), .BAout(outs[21]),
        .Cout(outs[20]), .Rout(outs[19]), .MARin(outs[18]), .PCin(outs[17]),
        .MDRin(outs[16]), .IRin(outs[15]), .Yin(outs[14]), .Zlowin(outs[13]),
        .Rin(outs[12]), .IncPc(outs[11]), .read(outs[10]), .write(outs[9]),
        .GRA(outs[8]), .GRB(outs[7]), .GRC(outs[6]), .mdr_read(outs[5:4]),
        .control(outs[3:0]), .halted(halted), .step(step)
    );

    ldst_control_unit #(.MEM_WAIT(1'b0)) dut_nw (
        .clk(clk), .reset(reset), .IRval(IRval), .mem_ready(mem_ready_nw), .stop(stop),
        .PCout(nw_outs[24]), .Zlowout(nw_outs[23]), .MDRout(nw_outs[22]), .BAout(nw_outs[21]),
        .Cout(nw_outs[20]), .Rout(nw_outs[19]), .MARin(nw_outs[18]), .PCin(nw_outs[17]),
        .MDRin(nw_outs[16]), .IRin(nw_outs[15]), .Yin(nw_outs[14]), .Zlowin(nw_outs[13]),
        .Rin(nw_outs[12]), .IncPc(nw_outs[11]), .read(nw_outs[10]), .write(nw_outs[9]),
        .GRA(nw_outs[8]), .GRB(nw_outs[7]), .GRC(nw_outs[6]), .mdr_read(nw_outs[5:4]),
        .control(nw_outs[3:0]), .halted(nw_halted), .step(nw_step)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_e s, input logic [24:0] o, input logic h);
        chk({tag, ":step"},   32'(step),   32'(s));
        chk({tag, ":outs"},   32'(outs),   32'(o));
        chk({tag, ":halted"}, 32'(halted), 32'(h));
    endtask

    task automatic check_nw(input string tag, input state_e s, input logic [24:0] o);
        chk({tag, ":nw_step"}, 32'(nw_step), 32'(s));
        chk({tag, ":nw_outs"}, 32'(nw_outs), 32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset        = 1'b0;
        stop         = 1'b0;
        mem_ready    = 1'b1;
        mem_ready_nw = 1'b0;
        IRval        = IR_LDI;

        // Reset held low
        tick();
        check_state("rst0", ST_RESET, E_ZERO, 1'b0);
        check_nw("rst0", ST_RESET, E_ZERO);
        tick();
        check_state("rst1", ST_RESET, E_ZERO, 1'b0);
        reset = 1'b1;

        // ldi, zero wait; the MEM_WAIT=0 copy runs with mem_ready low
        tick(); c0 = cyc;
        check_state("ldi_t0", ST_T0, E_T0, 1'b0);     check_nw("ldi_t0", ST_T0, E_T0);
        tick(); check_state("ldi_t1", ST_T1, E_T1, 1'b0);     check_nw("ldi_t1", ST_T1, E_T1);
        tick(); check_state("ldi_t2", ST_T2, E_T2, 1'b0);     check_nw("ldi_t2", ST_T2, E_T2);
        tick(); check_state("ldi_t3", ST_T3, E_T3, 1'b0);     check_nw("ldi_t3", ST_T3, E_T3);
        tick(); check_state("ldi_t4", ST_T4, E_T4, 1'b0);     check_nw("ldi_t4", ST_T4, E_T4);
        tick(); check_state("ldi_t5", ST_T5, E_T5_LDI, 1'b0); check_nw("ldi_t5", ST_T5, E_T5_LDI);
        tick(); check_state("ldi_next", ST_T0, E_T0, 1'b0);   check_nw("ldi_next", ST_T0, E_T0);
        chk("ldi_cycles", 32'(cyc - c0), 32'd6);

        // ldi with stop raised in T4
        tick(); tick(); tick(); tick();
        check_state("stop_t4", ST_T4, E_T4, 1'b0);
        stop = 1'b1;
        tick(); check_state("stop_t5", ST_T5, E_T5_LDI, 1'b0);
        tick(); check_state("stop_idle0", ST_IDLE, E_ZERO, 1'b0);
        tick(); check_state("stop_idle1", ST_IDLE, E_ZERO, 1'b0);
        stop = 1'b0;
        tick(); check_state("stop_resume", ST_T0, E_T0, 1'b0);

        // ld with 3 wait cycles in T1 and in T6
        IRval = IR_LD; mem_ready = 1'b0; c0 = cyc;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_state($sformatf("ld_t1_w%0d", i), ST_T1, E_T1, 1'b0);
            tick();
        end
        check_state("ld_t1_last", ST_T1, E_T1, 1'b0);
        mem_ready = 1'b1;
        tick(); check_state("ld_t2", ST_T2, E_T2, 1'b0);
        mem_ready = 1'b0;
        tick(); check_state("ld_t3", ST_T3, E_T3, 1'b0);
        tick(); check_state("ld_t4", ST_T4, E_T4, 1'b0);
        tick(); check_state("ld_t5", ST_T5, E_T5_MEM, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_state($sformatf("ld_t6_w%0d", i), ST_T6, E_T6_LD, 1'b0);
            tick();
        end
        check_state("ld_t6_last", ST_T6, E_T6_LD, 1'b0);
        mem_ready = 1'b1;
        tick(); check_state("ld_t7", ST_T7, E_T7_LD, 1'b0);
        tick(); check_state("ld_next", ST_T0, E_T0, 1'b0);
        chk("ld_cycles", 32'(cyc - c0), 32'd14);

        // st, T6 ignores mem_ready, T7 stalls one cycle
        IRval = IR_ST; c0 = cyc;
        tick(); check_state("st_t1", ST_T1, E_T1, 1'b0);
        tick(); check_state("st_t2", ST_T2, E_T2, 1'b0);
        tick(); check_state("st_t3", ST_T3, E_T3, 1'b0);
        tick(); check_state("st_t4", ST_T4, E_T4, 1'b0);
        tick(); check_state("st_t5", ST_T5, E_T5_MEM, 1'b0);
        mem_ready = 1'b0;
        tick(); check_state("st_t6", ST_T6, E_T6_ST, 1'b0);
        tick(); check_state("st_t7", ST_T7, E_T7_ST, 1'b0);
        tick(); check_state("st_t7_hold", ST_T7, E_T7_ST, 1'b0);
        mem_ready = 1'b1;
        tick(); check_state("st_next", ST_T0, E_T0, 1'b0);
        chk("st_cycles", 32'(cyc - c0), 32'd9);

        // Reset asserted mid-T6 of ld
        IRval = IR_LD;
        tick(); tick(); tick(); tick(); tick(); tick();
        check_state("ldrst_t6", ST_T6, E_T6_LD, 1'b0);
        #1 reset = 1'b0;
        #1;
        check_state("ldrst_async", ST_RESET, E_ZERO, 1'b0);
        chk("ldrst_opcode", 32'(dut.opcode_q), 32'd0);
        tick(); check_state("ldrst_hold", ST_RESET, E_ZERO, 1'b0);
        reset = 1'b1;
        tick(); check_state("ldrst_t0", ST_T0, E_T0, 1'b0);

        // Illegal opcode trap
        IRval = IR_BAD;
        tick(); check_state("bad_t1", ST_T1, E_T1, 1'b0);
        tick(); check_state("bad_t2", ST_T2, E_T2, 1'b0);
        tick(); check_state("bad_halt", ST_HALT, E_ZERO, 1'b1);
        chk("bad_opcode", 32'(dut.opcode_q), 32'd31);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            stop      = i[1];
            tick();
            check_state($sformatf("bad_stay%0d", i), ST_HALT, E_ZERO, 1'b1);
        end
        stop = 1'b0; mem_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_state("halt_rst", ST_RESET, E_ZERO, 1'b0);
        chk("halt_rst_opcode", 32'(dut.opcode_q), 32'd0);
        stop = 1'b1;
        tick();
        reset = 1'b1;
        tick(); check_state("rst_to_idle", ST_IDLE, E_ZERO, 1'b0);
        stop = 1'b0;
        tick(); check_state("idle_to_t0", ST_T0, E_T0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
